ddr_burst_controller: RTL and testbench
=======================================

Name: ddr_burst_controller

Overview:
Parametrised single-port memory controller model with valid/ready request handshake, multi-beat bursts, byte-lane write strobes and configurable read latency. It is the next-generation replacement for the fixed 32-bit, single-beat controller. It sits between the core's memory arbiter and the simulated DRAM storage array.

Parameters:
DATA_W, 32, data beat width in bits; multiple of 8.
ADDR_W, 32, byte-address width.
DEPTH, 1024, words of storage; power of 2.
MAX_BURST, 16, maximum beats per burst; power of 2.
RD_LATENCY, 2, cycles from request accept to first read beat; must be >= 1.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  controller accepts a request this cycle.
req_write  in  1  1 = write burst, 0 = read burst.
req_addr  in  ADDR_W  byte address of the first beat.
req_len  in  $clog2(MAX_BURST)  beats minus 1.
wr_data  in  DATA_W  write beat data.
wr_strb  in  DATA_W/8  byte enables for wr_data.
wr_valid  in  1  write beat present.
wr_ready  out  1  controller accepts a write beat.
rd_data  out  DATA_W  read beat data.
rd_valid  out  1  read beat valid.
rd_last  out  1  final read beat of the burst.
wr_done  out  1  one-cycle pulse when a write burst completes.
err  out  1  range error pulse; only active with the optional feature.

Behaviour:
- Reset (async): state = IDLE; req_ready=1; wr_ready=0; rd_valid=0; rd_last=0; wr_done=0; err=0; rd_data=0. Memory contents are not cleared.
- Word index = req_addr[$clog2(DATA_W/8) +: $clog2(DEPTH)]. Byte-offset bits are ignored. Upper bits above the index are ignored unless the optional feature is enabled.
- A request is accepted on a cycle where req_valid && req_ready. req_ready=1 only in IDLE. The controller latches addr, len and write.
- Beat address increments by 1 per beat and wraps modulo DEPTH (DEPTH-1 -> 0).
- States:
  - IDLE: on accept -> WRITE if req_write, else RD_WAIT.
  - WRITE: wr_ready=1. Each wr_valid beat writes only the byte lanes with wr_strb set. After beat len+1 -> WR_RESP.
  - WR_RESP: wr_done=1 for exactly one cycle -> IDLE.
  - RD_WAIT: count RD_LATENCY-1 cycles (zero cycles when RD_LATENCY=1) -> READ.
  - READ: rd_valid=1 for len+1 consecutive cycles, with no backpressure. rd_last=1 on the final beat only -> IDLE.
- Read latency: the first rd_valid is registered exactly RD_LATENCY cycles after the accept edge. rd_data holds its last value when rd_valid=0.
- req_ready reasserts the cycle after rd_last or wr_done. There are no back-to-back overlapping bursts.
- Gaps in wr_valid stall the WRITE state without timeout.
- wr_valid in any state other than WRITE is ignored (wr_ready=0).
- Read-after-write to the same word returns the new data, because the write completes before the read can be accepted.
- Reset asserted mid-burst aborts immediately and the controller returns to IDLE. Beats already written remain in memory. No wr_done or rd_last is issued.
- req_len=0 is a single-beat transfer: rd_valid and rd_last are asserted together.

Optional Feature:
Macro DDR_BURST_RANGE_CHECK_EN.
- With the macro: a request is in error if any req_addr bit above the word index is set, or if word index + req_len > DEPTH-1. An error request is still accepted and runs the normal state sequence, but:
  - writes consume their beats without modifying memory;
  - reads return rd_data=0;
  - err pulses for one cycle together with wr_done (write) or rd_last (read).
- Without the macro: err is tied to 0, and addresses wrap silently as described in Behaviour.

Test Plan:
- Single write then read: write addr 0x10, len 0, data 0xDEADBEEF, strb 0xF -> wr_done pulse. Read of 0x10 -> rd_valid with rd_last and rd_data=0xDEADBEEF exactly 2 cycles after accept.
- Byte strobes: word preloaded 0xDEADBEEF; write 0x11223344 with strb 0x5 -> read returns 0xDE22BE44.
- Burst with stalls: write 4 beats (len=3) of 0xA0..0xA3 at 0x40, wr_valid dropped for 2 cycles between beats 1 and 2 -> read burst gives 0xA0..0xA3 on 4 consecutive cycles, rd_last only on 0xA3.
- Wrap: 2-beat write at word 1023 -> data lands at words 1023 and 0. With DDR_BURST_RANGE_CHECK_EN: memory unchanged and err pulses with wr_done.
- Reset mid-read: assert reset during beat 2 of an 8-beat read -> rd_valid=0 immediately, req_ready=1 after release, and a new request is accepted normally.
- RD_LATENCY=1 build: read accept -> first rd_valid on the very next edge. req_valid held high -> the next accept occurs the cycle after rd_last.

Source files
------------

// File: rtl/ddr_burst_controller.sv
// ddr_burst_controller: single-port burst memory controller model.
// Valid/ready request handshake, multi-beat bursts with wrapping beat
// addresses, byte-lane write strobes and a fixed read latency.
// Optional range checking is enabled with `define DDR_BURST_RANGE_CHECK_EN.
module ddr_burst_controller #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int MAX_BURST  = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [$clog2(MAX_BURST)-1:0] req_len,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_strb,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic                         rd_last,
    output logic                         wr_done,
    output logic                         err
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LEN_W = $clog2(MAX_BURST);
    localparam int LAT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, RD_WAIT, READ} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  addr_q, addr_d;    // word index of the next beat
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;    // beats completed so far (minus 1 in READ)
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              bad_q, bad_d;      // current burst is out of range
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              wr_done_q, wr_done_d;
    logic              err_q, err_d;
    logic              mem_we, issue;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd;
    logic [IDX_W-1:0]  req_idx;
    logic              req_bad;
    logic              unused_addr;

    assign req_idx     = req_addr[OFF_W +: IDX_W];
    assign mem_rd      = mem[addr_q];
    assign unused_addr = ^req_addr;

`ifdef DDR_BURST_RANGE_CHECK_EN
    // Out of range: address bits above the word index, or burst runs past the end
    assign req_bad = ((req_addr >> (OFF_W + IDX_W)) != '0) ||
                     ((32'(req_idx) + 32'(req_len)) > 32'(DEPTH - 1));
`else
    assign req_bad = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign wr_ready  = (state_q == WRITE);
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign wr_done   = wr_done_q;
    assign err       = err_q;

    // Next-state and registered-output logic for the burst FSM
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        bad_d      = bad_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        wr_done_d  = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_idx;
                    len_d   = req_len;
                    beat_d  = '0;
                    lat_d   = '0;
                    bad_d   = req_bad;
                    state_d = req_write ? WRITE : RD_WAIT;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    mem_we = !bad_q;
                    addr_d = addr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        state_d   = WR_RESP;
                        wr_done_d = 1'b1;
                    end
                end
            end
            WR_RESP: state_d = IDLE;
            RD_WAIT: begin
                // The first beat is registered on the edge leaving this state
                if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
                    state_d   = READ;
                    issue     = 1'b1;
                    beat_d    = '0;
                    rd_last_d = (len_q == '0);
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            READ: begin
                if (beat_q == len_q) begin
                    state_d = IDLE;
                end else begin
                    issue     = 1'b1;
                    beat_d    = beat_q + 1'b1;
                    rd_last_d = (beat_d == len_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            rd_valid_d = 1'b1;
            rd_data_d  = bad_q ? '0 : mem_rd;
            addr_d     = addr_q + 1'b1;
        end
        err_d = bad_q && (rd_last_d || wr_done_d);
    end

    // State and output registers; reset aborts any burst in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
            bad_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            bad_q      <= bad_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            wr_done_q  <= wr_done_d;
            err_q      <= err_d;
        end
    end

    // Storage array with per-byte write enables; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_strb[b]) mem[addr_q][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ddr_burst_controller.sv
// Directed self-checking bench for ddr_burst_controller (default parameters).
module tb_ddr_burst_controller;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
    logic [31:0] req_addr = '0, wr_data = '0;
    logic [3:0]  req_len = '0, wr_strb = '0;
    logic        req_ready, wr_ready, rd_valid, rd_last, wr_done, err;
    logic [31:0] rd_data;

    int passed = 0, total = 0;

    logic [31:0] rbuf [16];
    logic        rlast [16];
    int          rn, rlat, rerr;
    logic        wdone, wdone_after, werr, wready_stall;

    ddr_burst_controller #(.RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .wr_done(wr_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write burst: beat b carries base+b; two idle cycles before beat stall_at
    task automatic do_write(input logic [31:0] a, input logic [3:0] l,
                            input logic [31:0] base, input logic [3:0] strb, input int stall_at);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
        step();
        req_valid = 1'b0;
        wready_stall = 1'b0;
        for (int b = 0; b <= int'(l); b++) begin
            if (b == stall_at) begin
                wr_valid = 1'b0;
                step();
                wready_stall = wr_ready;
                step();
            end
            wr_valid = 1'b1; wr_data = base + 32'(b); wr_strb = strb;
            step();
        end
        wr_valid = 1'b0;
        wdone = wr_done;
        werr = err;
        step();
        wdone_after = wr_done;
    endtask

    // Read burst: records beats and latency (steps after the accept edge)
    task automatic do_read(input logic [31:0] a, input logic [3:0] l);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        step();
        req_valid = 1'b0;
        rn = 0; rlat = -1; rerr = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (rd_valid) begin
                if (rlat < 0) rlat = k;
                if (rn < 16) begin
                    rbuf[rn] = rd_data;
                    rlast[rn] = rd_last;
                end
                if (err) rerr = 1;
                rn++;
            end else if (rlat >= 0) begin
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready got %b exp 0", wr_ready); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", rd_valid); else passed++;
        total++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last got %b exp 0", rd_last); else passed++;
        total++; if (wr_done !== 1'b0) $display("FAIL reset_wr_done got %b exp 0", wr_done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
        total++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data got %h exp 0", rd_data); else passed++;
        @(posedge clk); #1 reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        do_write(32'h10, 4'd0, 32'hDEADBEEF, 4'hF, -1);
        total++; if (wdone !== 1'b1) $display("FAIL single_wr_done got %b exp 1", wdone); else passed++;
        total++; if (wdone_after !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL single_wr_done_pulse got done=%b ready=%b exp 0/1", wdone_after, req_ready); else passed++;
        do_read(32'h10, 4'd0);
        total++; if (rlat !== LAT) $display("FAIL single_rd_latency got %0d exp %0d", rlat, LAT); else passed++;
        total++; if (rn !== 1 || rbuf[0] !== 32'hDEADBEEF || rlast[0] !== 1'b1)
            $display("FAIL single_rd_beat got n=%0d d=%h last=%b exp 1/deadbeef/1", rn, rbuf[0], rlast[0]); else passed++;
        total++; if (rd_valid !== 1'b0 || rd_data !== 32'hDEADBEEF)
            $display("FAIL single_rd_hold got v=%b d=%h exp 0/deadbeef", rd_valid, rd_data); else passed++;
    endtask

    task automatic test_strobes();
        do_write(32'h10, 4'd0, 32'h11223344, 4'h5, -1);
        do_read(32'h10, 4'd0);
        total++; if (rbuf[0] !== 32'hDE22BE44) $display("FAIL strobe_merge got %h exp de22be44", rbuf[0]); else passed++;
    endtask

    task automatic test_burst_stall();
        do_write(32'h50, 4'd0, 32'h12345678, 4'hF, -1);
        do_write(32'h40, 4'd3, 32'hA0, 4'hF, 2);
        total++; if (wready_stall !== 1'b1) $display("FAIL stall_wr_ready got %b exp 1", wready_stall); else passed++;
        total++; if (wdone !== 1'b1) $display("FAIL stall_wr_done got %b exp 1", wdone); else passed++;
        // Beat index now points at word 0x14; wr_valid in IDLE must not write
        wr_valid = 1'b1; wr_data = 32'hFFFFFFFF; wr_strb = 4'hF;
        step();
        total++; if (wr_ready !== 1'b0) $display("FAIL idle_wr_ready got %b exp 0", wr_ready); else passed++;
        step();
        wr_valid = 1'b0;
        do_read(32'h40, 4'd3);
        total++; if (rn !== 4) $display("FAIL burst_beats got %0d exp 4", rn); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rbuf[i] !== 32'hA0 + 32'(i) || rlast[i] !== (i == 3))
                $display("FAIL burst_beat%0d got d=%h last=%b exp %h/%b", i, rbuf[i], rlast[i], 32'hA0 + 32'(i), i == 3);
            else passed++;
        end
        do_read(32'h50, 4'd0);
        total++; if (rbuf[0] !== 32'h12345678) $display("FAIL idle_wr_ignored got %h exp 12345678", rbuf[0]); else passed++;
    endtask

    task automatic test_wrap();
        do_write(32'hFFC, 4'd0, 32'h11111111, 4'hF, -1);
        do_write(32'h000, 4'd0, 32'h22222222, 4'hF, -1);
        do_write(32'hFFC, 4'd1, 32'hB0, 4'hF, -1);
`ifdef DDR_BURST_RANGE_CHECK_EN
        total++; if (werr !== 1'b1 || wdone !== 1'b1) $display("FAIL wrap_err got err=%b done=%b exp 1/1", werr, wdone); else passed++;
        do_read(32'hFFC, 4'd0);
        total++; if (rbuf[0] !== 32'h11111111) $display("FAIL wrap_w1023 got %h exp 11111111", rbuf[0]); else passed++;
        do_read(32'h000, 4'd0);
        total++; if (rbuf[0] !== 32'h22222222) $display("FAIL wrap_w0 got %h exp 22222222", rbuf[0]); else passed++;
`else
        total++; if (werr !== 1'b0 || wdone !== 1'b1) $display("FAIL wrap_err got err=%b done=%b exp 0/1", werr, wdone); else passed++;
        do_read(32'hFFC, 4'd0);
        total++; if (rbuf[0] !== 32'hB0) $display("FAIL wrap_w1023 got %h exp b0", rbuf[0]); else passed++;
        do_read(32'h000, 4'd0);
        total++; if (rbuf[0] !== 32'hB1) $display("FAIL wrap_w0 got %h exp b1", rbuf[0]); else passed++;
`endif
    endtask

    task automatic test_reset_mid_read();
        int seen = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_len = 4'd7;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            step();
            if (rd_valid) seen++;
        end
        total++; if (seen !== 2) $display("FAIL midrd_beats got %0d exp 2", seen); else passed++;
        reset = 1'b1;
        #1;
        total++; if (rd_valid !== 1'b0 || rd_last !== 1'b0)
            $display("FAIL midrd_abort got v=%b last=%b exp 0/0", rd_valid, rd_last); else passed++;
        @(posedge clk); #1 reset = 1'b0;
        step();
        total++; if (req_ready !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL midrd_idle got ready=%b v=%b exp 1/0", req_ready, rd_valid); else passed++;
        do_read(32'h44, 4'd0);
        total++; if (rlat !== LAT || rbuf[0] !== 32'hA1)
            $display("FAIL midrd_new_req got lat=%0d d=%h exp %0d/a1", rlat, rbuf[0], LAT); else passed++;
    endtask

    task automatic test_back_to_back();
        int acc0 = -1, acc1 = -1, first_v = -1, lastc = -1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_len = 4'd1;
        for (int k = 0; k < 30; k++) begin
            if (rd_valid && first_v < 0) first_v = k;
            if (rd_last) lastc = k;
            if (req_ready) begin
                if (acc0 < 0) acc0 = k; else begin acc1 = k; break; end
            end
            step();
        end
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (rd_last) break;
        end
        step();
        total++; if (acc0 !== 0) $display("FAIL b2b_first_accept got %0d exp 0", acc0); else passed++;
        total++; if (first_v !== acc0 + 1 + LAT) $display("FAIL b2b_first_valid got %0d exp %0d", first_v, acc0 + 1 + LAT); else passed++;
        total++; if (lastc !== first_v + 1) $display("FAIL b2b_last got %0d exp %0d", lastc, first_v + 1); else passed++;
        total++; if (acc1 !== lastc + 1) $display("FAIL b2b_next_accept got %0d exp %0d", acc1, lastc + 1); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_strobes();
        test_burst_stall();
        test_wrap();
        test_reset_mid_read();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
